riscos_loader: RTL and testbench
================================

// Module: riscos_loader
// PURPOSE
//  Wishbone master that owns the SDRAM port while the HPS downloads the RISC OS image (ioctl index 1).
//  Zero-fills the ROM bank, then packs 16-bit ioctl words into 32-bit writes; the top level muxes SDRAM onto it while busy=1.
//  Sits between hps_io (ioctl side) and the sdram wishbone slave; core bus is held off during load.
// PARAMETERS
//  ROM_INDEX  8'd1   ioctl_index that selects a ROM download
//  ERASE_AW   20     erase/load word-address width (2^ERASE_AW 32-bit words)
//  ROM_BANK   2'b01  value for wb_adr[25:22]... placed above the ERASE_AW field (wb_adr = {ROM_BANK, word})
// PORTS
//  clk_sys         in   1   system clock
//  reset_n         in   1   async active-low reset
//  ioctl_download  in   1   HPS download active
//  ioctl_index     in   8   download target
//  ioctl_wr        in   1   one-cycle strobe, ioctl_dout/ioctl_addr valid
//  ioctl_addr      in   25  byte address (bit0 always 0)
//  ioctl_dout      in   16  halfword data
//  ioctl_wait      out  1   stall to hps_io
//  wb_cyc/wb_stb   out  1   wishbone cycle/strobe (always equal)
//  wb_we           out  1   always 1 while wb_stb
//  wb_sel          out  4   byte lanes
//  wb_adr          out  24  word address [25:2]
//  wb_dat_o        out  32  write data
//  wb_ack          in   1   slave acknowledge
//  busy            out  1   loader owns SDRAM (top-level mux select, core reset hold)
//  done            out  1   one-cycle pulse at load completion
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pend buffer empty. Reset mid-op aborts the bus cycle immediately.
//  dl = ioctl_download & (ioctl_index==ROM_INDEX). busy = (state!=IDLE).
//  IDLE: on dl rising edge -> ERASE, ctr<=0, ioctl_wait<=1.
//  ERASE: stb=1, sel=4'hF, dat=0, adr={ROM_BANK,ctr}. On ack: ctr==all-ones -> LOAD, ioctl_wait<=0; else ctr+1.
//   stb stays high across consecutive acks (back-to-back; new adr valid cycle after ack).
//  LOAD: on ioctl_wr: word w=ioctl_addr[ERASE_AW+1:2], half h=ioctl_addr[1].
//   - h=0: latch into pend (lo half, word w), no bus cycle; ioctl_wait stays 0.
//   - h=1 & pend valid & pend.w==w: issue sel=4'hF, dat={dout,pend.lo}; clear pend.
//   - h=1 otherwise: issue sel=4'b1100, dat={dout,dout} (flush pend first if valid).
//   - h=0 while pend valid for other word: flush pend (sel=4'b0011, dat={lo,lo}) then latch new.
//   Any issue: ioctl_wait<=1 same edge as accepting ioctl_wr -> WRITE (FLUSH first when flushing).
//  FLUSH: write pending lo half, on ack -> WRITE (or back to LOAD if only a latch follows).
//  WRITE: stb high until ack; on ack stb<=0, ioctl_wait<=0 -> LOAD. Exactly one ack consumed per cycle.
//  dl falls in LOAD: pend valid -> FLUSH then FIN; else FIN. dl falls in ERASE: finish erase, then FIN.
//  FIN: done=1 one cycle, busy=0 -> IDLE. ioctl_wr while ioctl_wait=1 is a protocol error; ignored.
//  Address wrap: ioctl_addr bits above ERASE_AW+1 ignored (modulo bank size).
//  ioctl_wr and ack same cycle in WRITE: ack completes current, wr ignored (wait still high).
// TESTING
//  ERASE_AW=4: dl rise -> 16 writes adr {01,0..15}, dat 0, sel F; ioctl_wait 1 until 16th ack, then 0.
//  Load addr0=16'h1234, addr2=16'hABCD -> one write adr {01,0}, sel F, dat 32'hABCD1234; wait released on ack.
//  Load addr0=16'h1111 then addr8=16'h2222 -> flush sel 0011 dat 1111_1111 @w0, later pend w2 on dl fall.
//  Load addr6=16'h5555 alone -> sel 1100 dat 5555_5555 adr {01,1}; wb_ack delayed 7 cycles keeps stb high, wait high.
//  dl drops with pend valid (addr4=16'h00FF) -> flush sel 0011 @w1, then done pulse, busy 0.
//  Assert reset_n low during WRITE -> stb, cyc, ioctl_wait, busy all 0 same cycle; index 3 download never sets busy.

Source files
------------

// File: rtl/riscos_loader.sv
// RISC OS ROM loader: owns the SDRAM wishbone port during an HPS ROM download,
// zero-fills the ROM bank, then packs 16-bit ioctl halfwords into 32-bit writes.

package riscos_loader_pkg;
  typedef struct packed {
    logic [23:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_wr_t;
endpackage

module riscos_loader
  import riscos_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX = 8'd1,
  parameter int unsigned ERASE_AW  = 20,
  parameter logic [1:0]  ROM_BANK  = 2'b01
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [23:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_LOAD, S_FLUSH, S_WRITE, S_FIN
  } state_t;

  // where a FLUSH cycle continues once its ack arrives
  typedef enum logic [1:0] {AFT_LOAD, AFT_WRITE, AFT_FIN} after_t;

  state_t                state_q, state_d;
  after_t                after_q, after_d;
  logic                  dl, dl_q;
  logic [ERASE_AW-1:0]   ctr_q, ctr_d;
  logic                  pend_v_q, pend_v_d;
  logic [ERASE_AW-1:0]   pend_w_q, pend_w_d;
  logic [15:0]           pend_lo_q, pend_lo_d;
  wb_wr_t                bus_q, bus_d, queued_q, queued_d;
  logic                  stb_q, stb_d, wait_q, wait_d, busy_q, busy_d, done_q, done_d;
  logic [ERASE_AW-1:0]   w_in;
  logic                  h_in;
  logic                  other_word;
  wb_wr_t                flush_wr;
  logic                  unused_addr;

  function automatic wb_wr_t mk_wr(input logic [ERASE_AW-1:0] w,
                                   input logic [3:0] s, input logic [31:0] d);
    wb_wr_t r;
    r.adr = 24'({ROM_BANK, w});
    r.sel = s;
    r.dat = d;
    return r;
  endfunction

  assign dl          = ioctl_download && (ioctl_index == ROM_INDEX);
  assign w_in        = ioctl_addr[ERASE_AW+1:2];
  assign h_in        = ioctl_addr[1];
  assign other_word  = pend_v_q && (pend_w_q != w_in);
  assign flush_wr    = mk_wr(pend_w_q, 4'b0011, {pend_lo_q, pend_lo_q});
  assign unused_addr = ^{ioctl_addr[24:ERASE_AW+2], ioctl_addr[0]};

  // state and datapath registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      after_q   <= AFT_LOAD;
      dl_q      <= 1'b0;
      ctr_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_w_q  <= '0;
      pend_lo_q <= '0;
      bus_q     <= '0;
      queued_q  <= '0;
      stb_q     <= 1'b0;
      wait_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      after_q   <= after_d;
      dl_q      <= dl;
      ctr_q     <= ctr_d;
      pend_v_q  <= pend_v_d;
      pend_w_q  <= pend_w_d;
      pend_lo_q <= pend_lo_d;
      bus_q     <= bus_d;
      queued_q  <= queued_d;
      stb_q     <= stb_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (dl && !dl_q) state_d = S_ERASE;
      S_ERASE: if (wb_ack && (ctr_q == '1)) state_d = S_LOAD;
      S_LOAD: begin
        if (!dl) begin
          state_d = pend_v_q ? S_FLUSH : S_FIN;
        end else if (ioctl_wr) begin
          if (h_in)            state_d = other_word ? S_FLUSH : S_WRITE;
          else if (other_word) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (wb_ack) begin
          unique case (after_q)
            AFT_WRITE: state_d = S_WRITE;
            AFT_LOAD:  state_d = S_LOAD;
            default:   state_d = S_FIN;
          endcase
        end
      end
      S_WRITE: if (wb_ack) state_d = S_LOAD;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath updates and next registered outputs
  always_comb begin
    ctr_d     = ctr_q;
    after_d   = after_q;
    pend_v_d  = pend_v_q;
    pend_w_d  = pend_w_q;
    pend_lo_d = pend_lo_q;
    bus_d     = bus_q;
    queued_d  = queued_q;

    unique case (state_q)
      S_IDLE: begin
        if (dl && !dl_q) begin
          ctr_d    = '0;
          pend_v_d = 1'b0;
          bus_d    = mk_wr('0, 4'hF, 32'h0);
        end
      end
      S_ERASE: begin
        if (wb_ack && (ctr_q != '1)) begin
          ctr_d = ctr_q + ERASE_AW'(1);
          bus_d = mk_wr(ctr_q + ERASE_AW'(1), 4'hF, 32'h0);
        end
      end
      S_LOAD: begin
        if (!dl) begin
          if (pend_v_q) begin
            bus_d    = flush_wr;
            after_d  = AFT_FIN;
            pend_v_d = 1'b0;
          end
        end else if (ioctl_wr) begin
          if (h_in) begin
            pend_v_d = 1'b0;
            if (pend_v_q && !other_word) begin
              bus_d = mk_wr(w_in, 4'hF, {ioctl_dout, pend_lo_q});
            end else if (other_word) begin
              bus_d    = flush_wr;
              queued_d = mk_wr(w_in, 4'b1100, {ioctl_dout, ioctl_dout});
              after_d  = AFT_WRITE;
            end else begin
              bus_d = mk_wr(w_in, 4'b1100, {ioctl_dout, ioctl_dout});
            end
          end else begin
            // the old lower half goes out while the new one is latched
            if (other_word) begin
              bus_d   = flush_wr;
              after_d = AFT_LOAD;
            end
            pend_v_d  = 1'b1;
            pend_w_d  = w_in;
            pend_lo_d = ioctl_dout;
          end
        end
      end
      S_FLUSH: begin
        if (wb_ack && (after_q == AFT_WRITE)) bus_d = queued_q;
      end
      default: ;
    endcase

    stb_d  = (state_d == S_ERASE) || (state_d == S_FLUSH) || (state_d == S_WRITE);
    wait_d = stb_d;
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  assign wb_cyc     = stb_q;
  assign wb_stb     = stb_q;
  assign wb_we      = stb_q;
  assign wb_sel     = bus_q.sel;
  assign wb_adr     = bus_q.adr;
  assign wb_dat_o   = bus_q.dat;
  assign ioctl_wait = wait_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_riscos_loader.sv
// Scoreboard bench for riscos_loader: a halfword-packing model queues expected
// wishbone writes, a slave/monitor process acks and compares them.

module tb_riscos_loader;
  import riscos_loader_pkg::*;

  localparam int unsigned AW     = 4;
  localparam int unsigned NWORDS = 1 << AW;
  localparam int unsigned BANK   = 1;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [23:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic        wb_ack = 1'b0;
  logic        busy, done;

  riscos_loader #(.ERASE_AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  int     checks = 0;
  int     failures = 0;
  wb_wr_t exp_q[$];
  int     fixed_delay = -1;
  bit     hold = 1'b0;

  // pending lower half as seen by the model
  bit          m_pv = 1'b0;
  int          m_pw = 0;
  logic [15:0] m_plo = '0;

  int     mon_cnt = 0;
  int     mon_dly = 0;
  wb_wr_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic wb_wr_t ex(input int w, input logic [3:0] s, input logic [31:0] d);
    wb_wr_t r;
    r.adr = 24'(BANK * NWORDS + (w % NWORDS));
    r.sel = s;
    r.dat = d;
    return r;
  endfunction

  // wishbone slave + scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_sys);
      if (wb_ack) begin
        wb_ack  = 1'b0;
        mon_cnt = 0;
      end
      if (!reset_n) begin
        wb_ack  = 1'b0;
        mon_cnt = 0;
      end else if (wb_stb && !hold) begin
        if (mon_cnt == 0)
          mon_dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        if (mon_cnt >= mon_dly) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual adr=%h sel=%h dat=%h required none",
                     wb_adr, wb_sel, wb_dat_o);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wb_write", 64'({wb_cyc, wb_we, wb_adr, wb_sel, wb_dat_o}),
                64'({2'b11, mon_e}));
          end
          wb_ack = 1'b1;
        end else begin
          mon_cnt++;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ioctl_wait && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    if (ioctl_wait) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout actual ioctl_wait=1 required 0");
    end
  endtask

  task automatic send(input logic [24:0] a, input logic [15:0] d);
    int w;
    wait_ready();
    w = int'((a >> 2) % NWORDS);
    if (a[1]) begin
      if (m_pv && m_pw == w) begin
        exp_q.push_back(ex(w, 4'hF, {d, m_plo}));
      end else begin
        if (m_pv) exp_q.push_back(ex(m_pw, 4'b0011, {m_plo, m_plo}));
        exp_q.push_back(ex(w, 4'b1100, {d, d}));
      end
      m_pv = 1'b0;
    end else begin
      if (m_pv && m_pw != w) exp_q.push_back(ex(m_pw, 4'b0011, {m_plo, m_plo}));
      m_pv  = 1'b1;
      m_pw  = w;
      m_plo = d;
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_download();
    ioctl_index = 8'd1;
    for (int i = 0; i < int'(NWORDS); i++) exp_q.push_back(ex(i, 4'hF, 32'h0));
    m_pv = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("erase_start", 64'({busy, ioctl_wait}), 64'(2'b11));
    wait_ready();
    chk("erase_done", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic end_download();
    bit got = 1'b0;
    wait_ready();
    if (m_pv) begin
      exp_q.push_back(ex(m_pw, 4'b0011, {m_plo, m_plo}));
      m_pv = 1'b0;
    end
    ioctl_download = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'(1));
    if (got) begin
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("flushed_at_done", 64'(exp_q.size()), 64'(0));
      @(negedge clk_sys);
      chk("done_one_cycle", 64'(done), 64'(0));
    end
  endtask

  initial begin
    logic [24:0] a;
    bit seen;
    #2;
    chk("reset_state", 64'({wb_cyc, wb_stb, wb_we, ioctl_wait, busy, done, wb_sel, wb_adr, wb_dat_o}),
        64'(0));
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // erase, then a full word from two halves
    start_download();
    send(25'h0, 16'h1234);
    send(25'h2, 16'hABCD);
    wait_ready();
    chk("pair_write_done", 64'(exp_q.size()), 64'(0));

    // lower half for another word forces a flush; leftover flushes at end
    send(25'h0, 16'h1111);
    send(25'h8, 16'h2222);
    end_download();

    // lone upper half with a slow slave
    start_download();
    fixed_delay = 7;
    send(25'h6, 16'h5555);
    for (int i = 0; i < 6; i++) chk("stall_hold", 64'({wb_stb, ioctl_wait}), 64'(2'b11));
    wait_ready();
    fixed_delay = -1;
    chk("single_write_done", 64'(exp_q.size()), 64'(0));
    send(25'h4, 16'h00FF);
    end_download();

    // randomized halves, with wrapping upper address bits
    start_download();
    for (int i = 0; i < 40; i++) begin
      a = 25'($urandom);
      a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        send(a, 16'($urandom));
        a[1] = 1'b1;
        send(a, 16'($urandom));
      end else begin
        a[1] = 1'($urandom);
        send(a, 16'($urandom));
      end
    end
    end_download();

    // reset in the middle of a stalled write
    start_download();
    hold = 1'b1;
    send(25'h6, 16'h7777);
    chk("write_stalled", 64'(wb_stb), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_abort", 64'({wb_stb, wb_cyc, ioctl_wait, busy}), 64'(0));
    exp_q.delete();
    m_pv = 1'b0;
    ioctl_download = 1'b0;
    hold = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // a download for another index leaves the loader idle
    ioctl_index = 8'd3;
    ioctl_download = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      seen = seen | busy | wb_stb;
    end
    chk("idx3_idle", 64'(seen), 64'(0));
    ioctl_download = 1'b0;
    @(negedge clk_sys);

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
